// File: rtl/lsu_word_bridge_pkg.sv
// Shared encodings for the load/store word bridge: opcodes, exception codes,
// FSM states, lane selectors and the latched-request record.
package lsu_word_bridge_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_RANGE    = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] BYTE0 = 2'd0;
  localparam logic [1:0] BYTE1 = 2'd1;
  localparam logic [1:0] BYTE2 = 2'd2;
  localparam logic [1:0] BYTE3 = 2'd3;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word accesses need both low bits clear, half accesses only bit 0.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (lane != BYTE0);
      OP_LH, OP_LHU, OP_SH: mis = lane[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_word_bridge_lane_unit.sv
// Combinational lane logic: extracts/extends load data from a word and merges
// sub-word store data into an old word. Little-endian lane numbering.
module lsu_lane_unit
  import lsu_word_bridge_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[7:0];
    case (lane)
      BYTE0:   sel_byte = word[7:0];
      BYTE1:   sel_byte = word[15:8];
      BYTE2:   sel_byte = word[23:16];
      BYTE3:   sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = (lane[1] == HALF_HI) ? word[31:16] : word[15:0];
  end

  always_comb begin
    rdata = '0;
    case (op)
      OP_LW:   rdata = word;
      OP_LH:   rdata = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  rdata = {16'h0000, sel_half};
      OP_LB:   rdata = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  rdata = {24'h000000, sel_byte};
      default: rdata = '0;
    endcase
  end

  // Only the addressed lane changes; every other byte keeps the old word.
  always_comb begin
    merged = word;
    case (op)
      OP_SW: merged = wdata;
      OP_SH: begin
        if (lane[1] == HALF_HI) merged[31:16] = wdata[15:0];
        else                    merged[15:0]  = wdata[15:0];
      end
      OP_SB: begin
        case (lane)
          BYTE0:   merged[7:0]   = wdata[7:0];
          BYTE1:   merged[15:8]  = wdata[7:0];
          BYTE2:   merged[23:16] = wdata[7:0];
          BYTE3:   merged[31:24] = wdata[7:0];
          default: merged        = word;
        endcase
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_word_bridge.sv
// Load/store bridge from the CPU memory stage to a word-wide data memory.
// Sub-word stores are done as read-modify-write; one request in flight.
module lsu_word_bridge
  import lsu_word_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 3072
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_exc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

  logic [1:0]  state;
  lsu_req_t    req_q;
  logic [1:0]  accept_exc;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  // Misalignment wins over range so a bad odd address reports as misaligned.
  always_comb begin
    accept_exc = EXC_NONE;
    if (is_misaligned(req_op, req_addr[1:0]))
      accept_exc = EXC_MISALIGN;
    else if ({1'b0, req_addr} >= ADDR_LIMIT)
      accept_exc = EXC_RANGE;
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign mem_write  = (state == ST_WR);

  lsu_lane_unit u_lane (
    .op     (req_q.op),
    .lane   (req_q.lane),
    .word   (mem_rdata),
    .wdata  (req_q.wdata),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  // mem_addr is loaded at accept so it is already valid during RD and WR;
  // mem_wdata is staged one cycle ahead so WR drives a registered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      resp_rdata <= '0;
      resp_exc   <= EXC_NONE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q.op    <= req_op;
            req_q.lane  <= req_addr[1:0];
            req_q.wdata <= req_wdata;
            resp_rdata  <= '0;
            resp_exc    <= accept_exc;
            if (accept_exc != EXC_NONE) begin
              state <= ST_RESP;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_op == OP_SW) begin
                mem_wdata <= req_wdata;
                state     <= ST_WR;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (is_store(req_q.op)) begin
            mem_wdata <= lane_merged;
            state     <= ST_WR;
          end else begin
            resp_rdata <= lane_rdata;
            state      <= ST_RESP;
          end
        end
        ST_WR: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_word_bridge.sv
// Self-checking bench for lsu_word_bridge: a word memory, a transaction-level
// reference model checked every cycle, and directed vectors with literal results.
module tb_lsu_word_bridge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_word_bridge #(.ADDR_W(32), .MEM_WORDS(3072)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, word write on posedge.
  logic [31:0] dmem [0:3071];
  logic [11:0] mem_idx;
  assign mem_idx   = mem_addr[13:2];
  assign mem_rdata = (mem_idx < 12'd3072) ? dmem[mem_idx] : 32'h0;
  always @(posedge clk) begin
    if (mem_write && mem_idx < 12'd3072) dmem[mem_idx] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [1:0] model_exc(input logic [2:0] op, input logic [31:0] addr);
    if ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) return 2'd1;
    if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0]) return 2'd1;
    if (addr >= 32'd12288) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [1:0] exc);
    if (exc != 2'd0) return 1;
    if (op == 3'd6 || op == 3'd7) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * addr[1:0]);
    case (op)
      3'd0:    return word;
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd2:    return {16'h0, s[15:0]};
      3'd3:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'h0, s[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh = 8 * addr[1:0];
    if (op == 3'd5) return wd;
    mask = (op == 3'd6) ? (32'h0000FFFF << sh) : (32'h000000FF << sh);
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  logic [31:0] ref_mem [0:3071];
  bit          m_live = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_write;
  int          m_edges;
  int          m_lat;
  logic [31:0] m_rdata;
  logic [31:0] m_newword;
  logic [31:0] m_aligned;
  logic [1:0]  m_exc;

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    if (addr < 32'd12288) return ref_mem[addr[13:2]];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live <= 1'b1;
      m_busy <= 1'b0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy    <= 1'b1;
          m_edges   <= 1;
          m_exc     <= model_exc(req_op, req_addr);
          m_lat     <= model_lat(req_op, model_exc(req_op, req_addr));
          m_write   <= (model_exc(req_op, req_addr) == 2'd0) && (req_op >= 3'd5);
          m_aligned <= {req_addr[31:2], 2'b00};
          m_rdata   <= (model_exc(req_op, req_addr) == 2'd0) ?
                       model_rdata(req_op, req_addr, ref_word(req_addr)) : 32'h0;
          m_newword <= model_merge(req_op, req_addr, ref_word(req_addr), req_wdata);
        end
      end else begin
        if (m_write && m_edges == m_lat - 1) ref_mem[m_aligned[13:2]] <= m_newword;
        if (m_edges >= m_lat && resp_ready) m_busy <= 1'b0;
        else m_edges <= m_edges + 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, m_busy && m_edges >= m_lat});
      checkOutput("mem_write", {31'b0, mem_write},
                  {31'b0, m_busy && m_write && m_edges == m_lat - 1});
      if (m_busy && m_exc == 2'd0 && m_edges < m_lat)
        checkOutput("mem_addr", mem_addr, m_aligned);
      if (m_busy && m_write && m_edges == m_lat - 1)
        checkOutput("mem_wdata", mem_wdata, m_newword);
      if (m_busy && m_edges >= m_lat) begin
        checkOutput("resp_rdata", resp_rdata, m_rdata);
        checkOutput("resp_exc", {30'b0, resp_exc}, {30'b0, m_exc});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                               input int stall, input logic [31:0] exp_rdata,
                               input logic [1:0] exp_exc, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("req_ready_wait", 32'd0, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    checkOutput("lit_rdata", resp_rdata, exp_rdata);
    checkOutput("lit_exc", {30'b0, resp_exc}, {30'b0, exp_exc});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput("stall_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("stall_rdata", resp_rdata, exp_rdata);
      checkOutput("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_drop", {31'b0, resp_valid}, 32'd0);
    checkOutput("ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_mem_write", {31'b0, mem_write}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_exc", {30'b0, resp_exc}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset during read-modify-write");
    applyStimulus(3'd5, 32'h20, 32'h55667788, 0, 32'h0, 2'd0, 2);
    req_valid = 1'b1;
    req_op    = 3'd7;
    req_addr  = 32'h21;
    req_wdata = 32'h000000AA;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rmw_rst_valid", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("rmw_rst_word", dmem[8], 32'h55667788);
    applyStimulus(3'd0, 32'h20, 32'h0, 0, 32'h55667788, 2'd0, 2);

    $display("[TB] word store and load");
    applyStimulus(3'd5, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2'd0, 2);
    applyStimulus(3'd0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2'd0, 2);

    $display("[TB] sub-word stores and loads");
    applyStimulus(3'd5, 32'h10, 32'h11223344, 0, 32'h0, 2'd0, 2);
    applyStimulus(3'd7, 32'h13, 32'h123456A5, 0, 32'h0, 2'd0, 3);
    checkOutput("sb_word", dmem[4], 32'hA5223344);
    applyStimulus(3'd3, 32'h13, 32'h0, 0, 32'hFFFFFFA5, 2'd0, 2);
    applyStimulus(3'd4, 32'h13, 32'h0, 0, 32'h000000A5, 2'd0, 2);
    applyStimulus(3'd1, 32'h12, 32'h0, 0, 32'hFFFFA522, 2'd0, 2);
    applyStimulus(3'd6, 32'h10, 32'hBEEFCAFE, 0, 32'h0, 2'd0, 3);
    applyStimulus(3'd0, 32'h10, 32'h0, 0, 32'hA522CAFE, 2'd0, 2);
    applyStimulus(3'd3, 32'h10, 32'h0, 0, 32'hFFFFFFFE, 2'd0, 2);
    applyStimulus(3'd4, 32'h11, 32'h0, 0, 32'h000000CA, 2'd0, 2);

    $display("[TB] exceptions");
    applyStimulus(3'd0, 32'h12, 32'h0, 0, 32'h0, 2'd1, 1);
    applyStimulus(3'd6, 32'h11, 32'hFFFF, 0, 32'h0, 2'd1, 1);
    applyStimulus(3'd5, 32'h13, 32'h0, 0, 32'h0, 2'd1, 1);
    checkOutput("exc_no_write", dmem[4], 32'hA522CAFE);
    applyStimulus(3'd0, 32'h3000, 32'h0, 0, 32'h0, 2'd2, 1);
    applyStimulus(3'd7, 32'h3000, 32'h55, 0, 32'h0, 2'd2, 1);
    applyStimulus(3'd1, 32'h3001, 32'h0, 0, 32'h0, 2'd1, 1);
    applyStimulus(3'd5, 32'h2FFC, 32'hCAFEF00D, 0, 32'h0, 2'd0, 2);
    applyStimulus(3'd0, 32'h2FFC, 32'h0, 0, 32'hCAFEF00D, 2'd0, 2);

    $display("[TB] back-pressure");
    applyStimulus(3'd5, 32'h14, 32'h80017FFF, 0, 32'h0, 2'd0, 2);
    applyStimulus(3'd2, 32'h16, 32'h0, 5, 32'h00008001, 2'd0, 2);
    applyStimulus(3'd1, 32'h14, 32'h0, 0, 32'h00007FFF, 2'd0, 2);
    applyStimulus(3'd1, 32'h16, 32'h0, 0, 32'hFFFF8001, 2'd0, 2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_word_bridge.md
Name: lsu_word_bridge

Overview:
- Load/store initiator between the CPU memory stage and the word-wide data memory.
- The data memory has a combinational read, a word-only write on posedge, and ignores address bits [1:0].
- This block converts byte, half and word loads/stores into word accesses. Sub-word stores use read-modify-write; loads are extracted and extended. Misaligned accesses are flagged without touching memory.
- Handshake on both the request and response sides, so the pipeline can stall on it.

Parameters:
- ADDR_W, 32, width of byte address on both sides.
- MEM_WORDS, 3072, memory depth in words; addresses at or beyond MEM_WORDS*4 raise an out-of-range exception.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data (low byte/half used for SB/SH)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data (0 for stores and exceptions)
- resp_exc  output  2  0 none, 1 misaligned, 2 out of range
- mem_addr  output  ADDR_W  word-aligned address to memory, bits [1:0] always 0
- mem_wdata  output  32  merged word to memory
- mem_write  output  1  memory write strobe, one cycle per write
- mem_rdata  input  32  combinational memory read of mem_addr

Behaviour:
- States: IDLE, RD, WR, RESP. Encoding is 2 bits.
- Reset (sync, any state, including mid-RMW):
  - state = IDLE.
  - req_ready = 1, resp_valid = 0, mem_write = 0.
  - resp_rdata = 0, resp_exc = 0, mem_addr = 0, mem_wdata = 0.
  - A pending RMW is abandoned with no write.
- Accept: req_valid & req_ready at posedge. The block latches op, addr, wdata and decodes the exception:
  - Misaligned: LW/SW with addr[1:0] != 0; LH/LHU/SH with addr[0] != 0.
  - Out of range: addr >= MEM_WORDS*4. Misaligned has priority.
- Transitions from IDLE after accept:
  - Exception -> RESP. No memory access.
  - LW/LH/LHU/LB/LBU -> RD.
  - SW -> WR.
  - SH/SB -> RD.
- RD:
  - mem_addr = {addr[31:2], 2'b00}. mem_rdata is sampled at the end of the cycle.
  - Load: extract the lane selected by addr[1:0] (little-endian; byte k = bits 8k+7:8k; half at addr[1]). Sign-extend for LH/LB, zero-extend for LHU/LBU. Result goes to resp_rdata; next state RESP.
  - Store (SH/SB): capture the old word; next state WR.
- WR:
  - mem_write = 1 for exactly this one cycle; mem_addr is the aligned address.
  - mem_wdata: SW uses wdata. SH/SB use the old word with only the addressed lane replaced by wdata[15:0] or wdata[7:0].
  - Next state RESP.
- RESP:
  - resp_valid = 1; outputs are held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE, and resp_valid drops the next cycle.
  - No new request is accepted in the same cycle as the response; req_ready rises the cycle after.
- Latency, accept edge to resp_valid high:
  - Exception: 1 cycle.
  - LW, SW: 2 cycles.
  - SH/SB: 3 cycles.
- Throughput: one request in flight.
- Outside WR, mem_write = 0. mem_addr and mem_wdata are don't-care for correctness but must be driven; mem_addr holds its last value.

Decomposition:
- Shared package:
  - req_op encodings.
  - exception codes.
  - state encodings.
  - Lane-select helper constants (BYTE0..BYTE3, HALF_LO/HI).
- One natural sub-module, lsu_lane_unit, purely combinational:
  - load_extract(op, addr[1:0], word) -> rdata.
  - store_merge(op, addr[1:0], old, wdata) -> new word.
  - Reused by a future byte-enable memory.

Test Plan:
- Reset mid-RMW: SB issued, reset asserted in RD -> no mem_write ever; next cycle req_ready=1, resp_valid=0; word unchanged.
- SW then LW at addr 0x10, wdata 0xDEADBEEF:
  - mem_write pulses once, 1 cycle after accept, mem_addr=0x10.
  - LW resp_rdata=0xDEADBEEF, resp_exc=0, resp_valid 2 cycles after accept.
- SB 0xA5 to 0x13 over word 0x11223344:
  - memory becomes 0xA5223344.
  - LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; LH 0x12 -> 0xFFFFA522.
- Misaligned and out of range:
  - LW 0x12 -> resp_exc=1 one cycle after accept, resp_rdata=0, no mem_write.
  - SH 0x11 -> resp_exc=1.
  - LW 0x3000 -> resp_exc=2.
- Back-pressure: resp_ready held 0 for 5 cycles after LHU 0x16 over word 0x8001_7FFF:
  - resp_valid stays 1, resp_rdata stays 0x00008001, req_ready=0 while stalled.
  - Request accepted the cycle after the handshake.
